router_input_port: RTL and testbench

ROUTER_INPUT_PORT -- requirements
Module: router_input_port

---
 rtl/router_input_port.sv | 154 +++++++++++++++
 tb/tb_router_input_port.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
// Credit-based router input port: DEPTH-entry flit FIFO plus a two-state
// packet FSM that computes XY routing from each head flit.
module router_input_port #(
   parameter int         DEPTH = 4,
   parameter logic [1:0] MY_X  = 2'd0,
   parameter logic [1:0] MY_Y  = 2'd0
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [19:0] in_data,
   input  logic        in_valid,
   output logic        credit_out,
   output logic [19:0] out_data,
   output logic        out_valid,
   output logic [2:0]  out_port,
   input  logic        out_ready,
   output logic        ovf_err,
   output logic        seq_err
);

   // state  | meaning
   // IDLE   | waiting for a head/single flit at the buffer head
   // ACTIVE | route latched, forwarding flits until a tail/single pops

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   localparam logic [1:0] FT_BODY   = 2'b00;
   localparam logic [1:0] FT_HEAD   = 2'b01;
   localparam logic [1:0] FT_TAIL   = 2'b10;
   localparam logic [1:0] FT_SINGLE = 2'b11;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_EAST  = 3'd1;
   localparam logic [2:0] PORT_WEST  = 3'd2;
   localparam logic [2:0] PORT_NORTH = 3'd3;
   localparam logic [2:0] PORT_SOUTH = 3'd4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   logic [19:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   state_e           state;
   logic [2:0]       route_q;
   logic             first_q;

   logic [19:0] head;
   logic [1:0]  head_type;
   logic [1:0]  dest_x;
   logic [1:0]  dest_y;
   logic        empty;
   logic        full;
   logic        head_is_start;
   logic        pop;
   logic        push;
   logic [2:0]  route_calc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign head          = mem[rd_ptr];
   assign head_type     = head[19:18];
   assign dest_x        = head[17:16];
   assign dest_y        = head[15:14];
   assign empty         = (count == '0);
   assign full          = (count == FULL_CNT);
   assign head_is_start = (head_type == FT_HEAD) || (head_type == FT_SINGLE);

   // IDLE pops only to discard stray body/tail flits; ACTIVE pops on grant.
   assign pop  = !empty && (((state == ST_ACTIVE) && out_ready) ||
                            ((state == ST_IDLE) && !head_is_start));
   assign push = in_valid && (!full || pop);

   always_comb begin
      route_calc = PORT_LOCAL;
      if (dest_x > MY_X)      route_calc = PORT_EAST;
      else if (dest_x < MY_X) route_calc = PORT_WEST;
      else if (dest_y > MY_Y) route_calc = PORT_NORTH;
      else if (dest_y < MY_Y) route_calc = PORT_SOUTH;
   end

   assign out_valid = (state == ST_ACTIVE) && !empty;
   assign out_data  = head;
   assign out_port  = route_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state      <= ST_IDLE;
         route_q    <= PORT_LOCAL;
         first_q    <= 1'b0;
         credit_out <= 1'b0;
         ovf_err    <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         credit_out <= pop;
         if (in_valid && full && !pop) ovf_err <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  if (head_is_start) begin
                     route_q <= route_calc;
                     first_q <= 1'b1;
                     state   <= ST_ACTIVE;
                  end else begin
                     seq_err <= 1'b1;
                  end
               end
            end
            ST_ACTIVE: begin
               if (pop) begin
                  first_q <= 1'b0;
                  // A head arriving mid-packet is forwarded but flagged.
                  if ((head_type == FT_HEAD) && !first_q) seq_err <= 1'b1;
                  if ((head_type == FT_TAIL) || (head_type == FT_SINGLE))
                     state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = ^{FT_BODY, PORT_LOCAL};

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port; two instances at (1,1) and (0,1)
// share stimulus so routing can be seen from two router positions.
module tb_router_input_port;

   logic        clk;
   logic        RST;
   logic [19:0] in_data;
   logic        in_valid;
   logic        out_ready;

   logic        credit_out, out_valid, ovf_err, seq_err;
   logic [19:0] out_data;
   logic [2:0]  out_port;

   logic        d2_credit_out, d2_out_valid, d2_ovf_err, d2_seq_err;
   logic [19:0] d2_out_data;
   logic [2:0]  d2_out_port;

   int checks   = 0;
   int failures = 0;

   router_input_port #(.DEPTH(4), .MY_X(2'd1), .MY_Y(2'd1)) u_dut (
      .clk(clk), .RST(RST), .in_data(in_data), .in_valid(in_valid),
      .credit_out(credit_out), .out_data(out_data), .out_valid(out_valid),
      .out_port(out_port), .out_ready(out_ready),
      .ovf_err(ovf_err), .seq_err(seq_err)
   );

   router_input_port #(.DEPTH(4), .MY_X(2'd0), .MY_Y(2'd1)) u_dut2 (
      .clk(clk), .RST(RST), .in_data(in_data), .in_valid(in_valid),
      .credit_out(d2_credit_out), .out_data(d2_out_data), .out_valid(d2_out_valid),
      .out_port(d2_out_port), .out_ready(out_ready),
      .ovf_err(d2_ovf_err), .seq_err(d2_seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] mk(input logic [1:0] t, input logic [1:0] x,
                                      input logic [1:0] y, input logic [13:0] p);
      return {t, x, y, p};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_d(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   task automatic chk_p(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; in_valid = 1'b0; in_data = '0;
      tick();
      RST = 1'b0;
   endtask

   logic [19:0] h, b1, b2, b3, t, x, s, h2, t2;

   initial begin
      RST = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      RST = 1'b0;
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk_b("rst_credit", credit_out, 1'b0);
      chk_b("rst_ovf", ovf_err, 1'b0);
      chk_b("rst_seq", seq_err, 1'b0);

      // Full packet to (3,1) from (1,1): EAST on every flit, four credits.
      h  = mk(2'b01, 2'd3, 2'd1, 14'h0A1);
      b1 = mk(2'b00, 2'd0, 2'd0, 14'h0B1);
      b2 = mk(2'b00, 2'd0, 2'd0, 14'h0B2);
      t  = mk(2'b10, 2'd0, 2'd0, 14'h0C1);
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = h;  tick();
      chk_b("pkt_idle_valid", out_valid, 1'b0);
      in_data = b1; tick();
      chk_b("pkt_valid_h", out_valid, 1'b1);
      chk_d("pkt_data_h", out_data, h);
      chk_p("pkt_port_h", out_port, 3'd1);
      chk_b("pkt_no_credit_yet", credit_out, 1'b0);
      in_data = b2; tick();
      chk_b("pkt_credit1", credit_out, 1'b1);
      chk_d("pkt_data_b1", out_data, b1);
      chk_p("pkt_port_b1", out_port, 3'd1);
      in_data = t; tick();
      chk_b("pkt_credit2", credit_out, 1'b1);
      chk_d("pkt_data_b2", out_data, b2);
      in_valid = 1'b0; tick();
      chk_b("pkt_credit3", credit_out, 1'b1);
      chk_d("pkt_data_t", out_data, t);
      chk_p("pkt_port_t", out_port, 3'd1);
      tick();
      chk_b("pkt_credit4", credit_out, 1'b1);
      chk_b("pkt_idle_after", out_valid, 1'b0);
      tick();
      chk_b("pkt_credit_end", credit_out, 1'b0);
      chk_b("pkt_ovf", ovf_err, 1'b0);
      chk_b("pkt_seq", seq_err, 1'b0);

      // Overflow: fifth flit dropped and never forwarded.
      do_reset();
      x = mk(2'b00, 2'd0, 2'd0, 14'h3FFF);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = h;  tick();
      in_data = b1; tick();
      in_data = b2; tick();
      in_data = t;  tick();
      chk_b("ovf_before", ovf_err, 1'b0);
      in_data = x;  tick();
      chk_b("ovf_set", ovf_err, 1'b1);
      chk_d("ovf_head", out_data, h);
      in_valid = 1'b0; out_ready = 1'b1; tick();
      chk_d("ovf_drain_b1", out_data, b1);
      tick();
      chk_d("ovf_drain_b2", out_data, b2);
      tick();
      chk_d("ovf_drain_t", out_data, t);
      tick();
      chk_b("ovf_drained", out_valid, 1'b0);
      chk_b("ovf_sticky", ovf_err, 1'b1);

      // Full FIFO, simultaneous push/pop across pointer wrap.
      do_reset();
      b3 = mk(2'b00, 2'd0, 2'd0, 14'h0B3);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = h;  tick();
      in_data = b1; tick();
      in_data = b2; tick();
      in_data = b3; tick();
      out_ready = 1'b1;
      in_data = mk(2'b00, 2'd0, 2'd0, 14'h0B4); tick();
      chk_b("wrap_no_ovf", ovf_err, 1'b0);
      chk_d("wrap_b1", out_data, b1);
      chk_b("wrap_credit", credit_out, 1'b1);
      in_data = mk(2'b00, 2'd0, 2'd0, 14'h0B5); tick();
      chk_d("wrap_b2", out_data, b2);
      in_data = t; tick();
      chk_d("wrap_b3", out_data, b3);
      in_valid = 1'b0; tick();
      chk_d("wrap_b4", out_data, mk(2'b00, 2'd0, 2'd0, 14'h0B4));
      tick();
      chk_d("wrap_b5", out_data, mk(2'b00, 2'd0, 2'd0, 14'h0B5));
      tick();
      chk_d("wrap_t", out_data, t);
      chk_b("wrap_still_valid", out_valid, 1'b1);
      tick();
      chk_b("wrap_done", out_valid, 1'b0);
      chk_b("wrap_ovf_end", ovf_err, 1'b0);

      // Stray body flit while idle: discarded with one credit.
      do_reset();
      in_valid = 1'b1; in_data = b1; tick();
      chk_b("stray_valid0", out_valid, 1'b0);
      in_valid = 1'b0; tick();
      chk_b("stray_seq", seq_err, 1'b1);
      chk_b("stray_credit", credit_out, 1'b1);
      chk_b("stray_valid1", out_valid, 1'b0);
      tick();
      chk_b("stray_credit_once", credit_out, 1'b0);
      chk_b("stray_valid2", out_valid, 1'b0);

      // Single flit to (1,1) then head to (0,2).
      do_reset();
      s  = mk(2'b11, 2'd1, 2'd1, 14'h051);
      h2 = mk(2'b01, 2'd0, 2'd2, 14'h0A2);
      t2 = mk(2'b10, 2'd0, 2'd0, 14'h0C2);
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = s; tick();
      in_data = h2; tick();
      chk_d("single_data", out_data, s);
      chk_p("single_local", out_port, 3'd0);
      chk_p("single_d2_east", d2_out_port, 3'd1);
      in_data = t2; tick();
      chk_b("single_idle", out_valid, 1'b0);
      chk_b("single_credit", credit_out, 1'b1);
      in_valid = 1'b0; tick();
      chk_d("h2_data", out_data, h2);
      chk_p("h2_d1_west", out_port, 3'd2);
      chk_p("h2_d2_north", d2_out_port, 3'd3);
      tick();
      chk_d("t2_data", out_data, t2);
      tick();
      chk_b("t2_idle", out_valid, 1'b0);
      chk_b("t2_seq", seq_err, 1'b0);

      // Head flit inside a packet: forwarded, flagged.
      do_reset();
      in_valid = 1'b1; in_data = h; tick();
      in_data = h2; tick();
      in_data = t; tick();
      chk_d("midhead_data", out_data, h2);
      chk_b("midhead_seq_before", seq_err, 1'b0);
      in_valid = 1'b0; tick();
      chk_b("midhead_seq", seq_err, 1'b1);
      chk_d("midhead_tail", out_data, t);
      tick();
      chk_b("midhead_idle", out_valid, 1'b0);

      // Reset with three flits buffered.
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = h;  tick();
      in_data = b1; tick();
      in_data = b2; tick();
      chk_b("rstmid_active", out_valid, 1'b1);
      in_valid = 1'b0; RST = 1'b1; tick();
      RST = 1'b0; out_ready = 1'b1;
      chk_b("rstmid_valid", out_valid, 1'b0);
      chk_b("rstmid_credit", credit_out, 1'b0);
      chk_b("rstmid_seq", seq_err, 1'b0);
      chk_b("rstmid_ovf", ovf_err, 1'b0);
      tick();
      chk_b("rstmid_empty1", out_valid, 1'b0);
      chk_b("rstmid_credit1", credit_out, 1'b0);
      tick();
      chk_b("rstmid_empty2", out_valid, 1'b0);
      chk_b("rstmid_credit2", credit_out, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
